// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, state type and fixed-point rescaling helper.
// Constants are kept at a high-precision reference scale and rescaled per instance width.
package cordic_pkg;

  localparam int REF_FRAC = 30;
  localparam int ATAN_N   = 32;

  // atan(2^-i) with REF_FRAC fractional bits
  localparam logic signed [63:0] ATAN_TABLE [ATAN_N] = '{
    64'sh3243F6A8, 64'sh1DAC6705, 64'sh0FADBAFC, 64'sh07F56EA6,
    64'sh03FEAB76, 64'sh01FFD55B, 64'sh00FFFAAA, 64'sh007FFF55,
    64'sh003FFFEA, 64'sh001FFFFD, 64'sh000FFFFF, 64'sh0007FFFF,
    64'sh0003FFFF, 64'sh0001FFFF, 64'sh0000FFFF, 64'sh00007FFF,
    64'sh00003FFF, 64'sh00001FFF, 64'sh00000FFF, 64'sh000007FF,
    64'sh000003FF, 64'sh000001FF, 64'sh000000FF, 64'sh0000007F,
    64'sh0000003F, 64'sh0000001F, 64'sh0000000F, 64'sh00000007,
    64'sh00000003, 64'sh00000001, 64'sh00000000, 64'sh00000000
  };

  localparam logic signed [63:0] PI_FIX      = 64'sd3373259426;
  localparam logic signed [63:0] HALF_PI_FIX = 64'sd1686629713;
  localparam logic signed [63:0] CORDIC_GAIN = 64'sd1768195361;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Round a REF_FRAC value to `frac` fractional bits (frac < REF_FRAC).
  function automatic logic signed [63:0] ref_to_frac(input logic signed [63:0] v,
                                                     input int frac);
    logic signed [63:0] half;
    half = 64'sd1 <<< (REF_FRAC - frac - 1);
    return (v + half) >>> (REF_FRAC - frac);
  endfunction

endpackage

// File: rtl/cordic_microrotation.sv
// One combinational CORDIC micro-rotation; direction is supplied by the caller so the
// same block serves both vectoring and rotation modes.
module cordic_microrotation
  import cordic_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int FRAC   = 21,
  parameter int IDX_W  = 5
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  input  logic signed [DATA_W-1:0] z,
  input  logic        [IDX_W-1:0]  i,
  input  logic                     d_neg,
  output logic signed [DATA_W-1:0] x_nxt,
  output logic signed [DATA_W-1:0] y_nxt,
  output logic signed [DATA_W-1:0] z_nxt
);

  logic signed [DATA_W-1:0] x_sh;
  logic signed [DATA_W-1:0] y_sh;
  logic signed [DATA_W-1:0] atan_i;

  always_comb begin
    x_sh   = x >>> i;
    y_sh   = y >>> i;
    atan_i = DATA_W'(ref_to_frac(ATAN_TABLE[i], FRAC));
    if (d_neg) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_i;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: (x, y) -> (atan2(y, x), K*|v|), one micro-rotation
// per clock with two extra fractional guard bits in the working registers.
module cordic_vectoring_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH      = 22,
  parameter int NUM_STAGES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] angle_out,
  output logic signed [WIDTH-1:0] mag_out
);

  localparam int GUARD  = 2;
  localparam int IW     = WIDTH + GUARD;
  localparam int FRAC_I = WIDTH - 3 + GUARD;
  localparam int IDX_W  = $clog2(WIDTH);
  localparam int CNT_W  = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0]     LAST      = CNT_W'(NUM_STAGES);
  localparam logic signed [IW-1:0] HALF_PI_I = IW'(ref_to_frac(HALF_PI_FIX, FRAC_I));
  localparam logic signed [IW-1:0] PI_O      = IW'(ref_to_frac(PI_FIX, WIDTH - 3));

  function automatic logic signed [WIDTH-1:0] sat_angle(input logic signed [IW-1:0] z);
    logic signed [IW-1:0] t;
    t = z >>> GUARD;
    if (t > PI_O)       return WIDTH'(PI_O);
    else if (t < -PI_O) return WIDTH'(-PI_O);
    else                return WIDTH'(t);
  endfunction

  function automatic logic signed [WIDTH-1:0] trunc_mag(input logic signed [IW-1:0] v);
    return WIDTH'(v >>> GUARD);
  endfunction

  state_t               state_p, state_nxt;
  logic [CNT_W-1:0]     cnt_p;
  logic signed [IW-1:0] x_p0, y_p0, z_p0;
  logic                 zero_p0;
  logic signed [IW-1:0] x_ext, y_ext, x_pre, y_pre, z_pre;
  logic signed [IW-1:0] x_nxt, y_nxt, z_nxt;
  logic                 accept, iterating, finishing;

  assign accept    = (state_p == IDLE) && in_valid;
  assign iterating = (state_p == RUN) && (cnt_p != LAST);
  assign finishing = (state_p == RUN) && (cnt_p == LAST);

  // Quadrant pre-rotation folds the left half-plane into |angle| <= pi/2
  always_comb begin
    x_ext = IW'(x_in) <<< GUARD;
    y_ext = IW'(y_in) <<< GUARD;
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = '0;
    if (x_in[WIDTH-1]) begin
      if (!y_in[WIDTH-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = HALF_PI_I;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = -HALF_PI_I;
      end
    end
  end

  cordic_microrotation #(
    .DATA_W (IW),
    .FRAC   (FRAC_I),
    .IDX_W  (IDX_W)
  ) u_micro (
    .x     (x_p0),
    .y     (y_p0),
    .z     (z_p0),
    .i     (IDX_W'(cnt_p)),
    .d_neg (y_p0[IW-1]),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .z_nxt (z_nxt)
  );

  // Stage p0: working vector, loaded on accept and rotated while iterating
  always_ff @(posedge clk) begin
    if (accept) begin
      x_p0    <= x_pre;
      y_p0    <= y_pre;
      z_p0    <= z_pre;
      zero_p0 <= (x_in == '0) && (y_in == '0);
    end else if (iterating) begin
      x_p0 <= x_nxt;
      y_p0 <= y_nxt;
      z_p0 <= z_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_p <= IDLE;
    else          state_p <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p;
    unique case (state_p)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (finishing) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_p == IDLE);
    out_valid = (state_p == DONE);
  end

  // Output stage: results captured once on entry to DONE and held until the next one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p     <= '0;
      angle_out <= '0;
      mag_out   <= '0;
    end else begin
      if (iterating) cnt_p <= cnt_p + 1'b1;
      else           cnt_p <= '0;
      if (finishing) begin
        angle_out <= zero_p0 ? '0 : sat_angle(z_p0);
        mag_out   <= trunc_mag(x_p0);
      end
    end
  end

endmodule
